// File: rtl/led_pwm_user_logic.sv
// -----------------------------------------------------------------------------
// led_pwm_user_logic
// Parametrised LED driver that sits beside the AXI-Lite custom IP slave. It
// decodes four write-only registers from the slave's write port and drives
// NUM_LEDS outputs in static, blink or PWM-dimming mode.
//
// Register map (word index = axi_awaddr[ADDR-1:2]):
//   0 LED_VAL[NUM_LEDS-1:0]   1 MODE[1:0]   2 DUTY[PWM_WIDTH-1:0]
//   3 BLINK_DIV[DIV_WIDTH-1:0]   (other indices ignored)
//
// Ports:
//   S_AXI_ACLK     in  clock, all logic on rising edge
//   S_AXI_ARESETN  in  synchronous reset, active HIGH despite the name
//   slv_reg_wren   in  write strobe, one cycle per write
//   axi_awaddr     in  latched byte write address
//   S_AXI_WDATA    in  32-bit write data
//   LED            out registered LED drive
// -----------------------------------------------------------------------------
module led_pwm_user_logic #(
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
    parameter int unsigned NUM_LEDS           = 8,
    parameter int unsigned PWM_WIDTH          = 8,
    parameter int unsigned DIV_WIDTH          = 24
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic                          slv_reg_wren,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] axi_awaddr,
    input  logic [31:0]                   S_AXI_WDATA,
    output logic [NUM_LEDS-1:0]           LED
);

    localparam int unsigned IDX_W = C_S_AXI_ADDR_WIDTH - 2;

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_BLINK  = 2'd1;
    localparam logic [1:0] MODE_PWM    = 2'd2;

    logic [IDX_W-1:0]     wr_idx;
    logic                 wr_led;
    logic                 wr_mode;
    logic                 wr_duty;
    logic                 wr_div;
    logic                 wr_blink_start;

    logic [NUM_LEDS-1:0]  led_val;
    logic [1:0]           mode;
    logic [PWM_WIDTH-1:0] duty;
    logic [DIV_WIDTH-1:0] blink_div;

    logic [PWM_WIDTH-1:0] pwm_cnt;
    logic [DIV_WIDTH-1:0] blk_cnt;
    logic                 phase;

    logic                 pwm_on;
    logic                 blk_hit;
    logic [NUM_LEDS-1:0]  led_nxt;

    // Bits of the write port that no register field consumes.
    logic                 unused_wr_bits;
    assign unused_wr_bits = ^{S_AXI_WDATA, axi_awaddr[1:0]};

    // Register-select decode.
    assign wr_idx         = axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_led         = slv_reg_wren && (wr_idx == IDX_W'(0));
    assign wr_mode        = slv_reg_wren && (wr_idx == IDX_W'(1));
    assign wr_duty        = slv_reg_wren && (wr_idx == IDX_W'(2));
    assign wr_div         = slv_reg_wren && (wr_idx == IDX_W'(3));
    assign wr_blink_start = wr_mode && (S_AXI_WDATA[1:0] == MODE_BLINK);

    // Control registers.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESETN) begin
            led_val   <= '0;
            mode      <= '0;
            duty      <= '0;
            blink_div <= '0;
        end else begin
            if (wr_led)  led_val   <= S_AXI_WDATA[NUM_LEDS-1:0];
            if (wr_mode) mode      <= S_AXI_WDATA[1:0];
            if (wr_duty) duty      <= S_AXI_WDATA[PWM_WIDTH-1:0];
            if (wr_div)  blink_div <= S_AXI_WDATA[DIV_WIDTH-1:0];
        end
    end

    // Free-running PWM counter, wraps naturally at 2^PWM_WIDTH.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESETN) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_WIDTH'(1);
        end
    end

    assign pwm_on  = (pwm_cnt < duty);
    assign blk_hit = (blk_cnt == blink_div);

    // Blink divider and phase. Entering blink mode restarts lit; rewriting the
    // divider restarts the count and swallows any toggle due this cycle.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESETN) begin
            blk_cnt <= '0;
            phase   <= 1'b0;
        end else if (wr_blink_start) begin
            blk_cnt <= '0;
            phase   <= 1'b1;
        end else if (wr_div) begin
            blk_cnt <= '0;
        end else if (blk_hit) begin
            blk_cnt <= '0;
            phase   <= ~phase;
        end else begin
            blk_cnt <= blk_cnt + DIV_WIDTH'(1);
        end
    end

    // Output mux; reserved mode 3 falls through to static.
    always_comb begin
        led_nxt = led_val;
        case (mode)
            MODE_BLINK: led_nxt = led_val & {NUM_LEDS{phase}};
            MODE_PWM:   led_nxt = led_val & {NUM_LEDS{pwm_on}};
            default:    led_nxt = led_val;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESETN) begin
            LED <= '0;
        end else begin
            LED <= led_nxt;
        end
    end

endmodule

// File: tb/tb_led_pwm_user_logic.sv
// -----------------------------------------------------------------------------
// tb_led_pwm_user_logic
// Directed bench for led_pwm_user_logic with NUM_LEDS=8, PWM_WIDTH=4,
// DIV_WIDTH=8 and a 5-bit address so that an unmapped index exists.
// -----------------------------------------------------------------------------
module tb_led_pwm_user_logic;

    localparam logic [4:0] A_LED  = 5'h00;
    localparam logic [4:0] A_MODE = 5'h04;
    localparam logic [4:0] A_DUTY = 5'h08;
    localparam logic [4:0] A_DIV  = 5'h0C;
    localparam logic [4:0] A_UNM  = 5'h10;

    logic        clk;
    logic        rst;
    logic        wren;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  led;

    int n_checks;
    int n_fail;

    led_pwm_user_logic #(
        .C_S_AXI_ADDR_WIDTH (5),
        .NUM_LEDS           (8),
        .PWM_WIDTH          (4),
        .DIV_WIDTH          (8)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst),
        .slv_reg_wren  (wren),
        .axi_awaddr    (addr),
        .S_AXI_WDATA   (wdata),
        .LED           (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1ns after.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wren  = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        wren  = 1'b0;
        addr  = '0;
        wdata = '0;
    endtask

    // Sample 16 consecutive LED values: how many equal 'on_val', how many are
    // neither 'on_val' nor zero.
    task automatic pwm_window(input logic [7:0] on_val, output int on_cnt, output int bad_cnt);
        on_cnt  = 0;
        bad_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (led == on_val) on_cnt++;
            else if (led != 8'h00) bad_cnt++;
        end
    endtask

    initial begin
        int         on_cnt;
        int         bad_cnt;
        int         toggles;
        logic [7:0] prev;
        logic [7:0] exp;

        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        wren     = 1'b0;
        addr     = '0;
        wdata    = '0;

        // Writes while reset is held must be dropped.
        wr(A_LED, 32'h0000_00FF);
        check_eq("rst_led_0", 32'(led), 32'h00);
        wr(A_MODE, 32'h0000_0002);
        check_eq("rst_led_1", 32'(led), 32'h00);
        wr(A_DUTY, 32'h0000_000F);
        check_eq("rst_led_2", 32'(led), 32'h00);
        rst = 1'b0;
        tick();
        tick();
        check_eq("post_rst_led", 32'(led), 32'h00);

        // Static write latency: register at edge N, LED at N+1.
        wr(A_LED, 32'h0000_00A5);
        check_eq("a5_edge_n", 32'(led), 32'h00);
        tick();
        check_eq("a5_edge_n1", 32'(led), 32'hA5);

        // Upper WDATA bits ignored; unmapped index ignored.
        wr(A_LED, 32'hFFFF_FF3C);
        tick();
        check_eq("led_3c", 32'(led), 32'h3C);
        wr(A_UNM, 32'h0000_0055);
        tick();
        check_eq("unmapped_0", 32'(led), 32'h3C);
        tick();
        check_eq("unmapped_1", 32'(led), 32'h3C);

        // Blink, half-period 4, starts lit after MODE=1.
        wr(A_LED, 32'h0000_00FF);
        wr(A_DIV, 32'h0000_0003);
        wr(A_MODE, 32'h0000_0001);
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp = (i <= 4) ? 8'hFF : 8'h00;
            check_eq($sformatf("blink_div3_%0d", i), 32'(led), 32'(exp));
        end

        // BLINK_DIV=0: toggle every cycle.
        wr(A_DIV, 32'h0000_0000);
        tick();
        prev    = led;
        toggles = 0;
        bad_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (led != prev) toggles++;
            if (led != 8'hFF && led != 8'h00) bad_cnt++;
            prev = led;
        end
        check_eq("blink_div0_toggles", 32'(toggles), 32'd8);
        check_eq("blink_div0_values", 32'(bad_cnt), 32'd0);

        // Divider rewrite on the hit cycle: no toggle, count restarts.
        wr(A_DIV, 32'h0000_0003);
        wr(A_MODE, 32'h0000_0001);
        tick();
        tick();
        tick();
        wr(A_DIV, 32'h0000_0003);
        check_eq("hit_wr_lit_0", 32'(led), 32'hFF);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_eq($sformatf("hit_wr_lit_%0d", i), 32'(led), 32'hFF);
        end
        tick();
        check_eq("hit_wr_dark", 32'(led), 32'h00);

        // PWM dimming.
        wr(A_LED, 32'h0000_000F);
        wr(A_DUTY, 32'hFFFF_FFF4);
        wr(A_MODE, 32'h0000_0002);
        tick();
        pwm_window(8'h0F, on_cnt, bad_cnt);
        check_eq("pwm_duty4_on", 32'(on_cnt), 32'd4);
        check_eq("pwm_duty4_bad", 32'(bad_cnt), 32'd0);
        wr(A_DUTY, 32'h0000_0000);
        tick();
        pwm_window(8'h0F, on_cnt, bad_cnt);
        check_eq("pwm_duty0_on", 32'(on_cnt), 32'd0);
        check_eq("pwm_duty0_bad", 32'(bad_cnt), 32'd0);
        wr(A_DUTY, 32'h0000_000F);
        tick();
        pwm_window(8'h0F, on_cnt, bad_cnt);
        check_eq("pwm_duty15_on", 32'(on_cnt), 32'd15);
        check_eq("pwm_duty15_bad", 32'(bad_cnt), 32'd0);

        // Reset mid-blink while lit.
        wr(A_LED, 32'h0000_00FF);
        wr(A_DIV, 32'h0000_0003);
        wr(A_MODE, 32'h0000_0001);
        tick();
        check_eq("pre_rst_lit", 32'(led), 32'hFF);
        rst = 1'b1;
        tick();
        check_eq("mid_rst_led", 32'(led), 32'h00);
        tick();
        tick();
        rst = 1'b0;

        // After release: mode is static, PWM counter restarted from 0.
        wr(A_LED, 32'h0000_00FF);
        wr(A_DUTY, 32'h0000_0008);
        check_eq("mode0_after_rst", 32'(led), 32'hFF);
        wr(A_MODE, 32'h0000_0002);
        for (int j = 4; j <= 19; j++) begin
            tick();
            exp = (((j - 1) % 16) < 8) ? 8'hFF : 8'h00;
            check_eq($sformatf("pwm_phase_rst_%0d", j), 32'(led), 32'(exp));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
